// File: rtl/data_ram_responder.sv
// data_ram_responder: responder side of the MEM-stage data memory interface.
// Word-organised RAM with byte-lane writes, a programmable number of wait
// states per access, a combinational stall while busy and a one-cycle ready.
module data_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        ram_ready,
    output logic        ram_stall,
    output logic        addr_fault
);

    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [3:0]            r_we;
    logic [31:0]           r_wdata;
    logic                  r_fault;
    logic [31:0]           r_read_data;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_oor;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [3:0]            w_we;
    logic [31:0]           w_wdata;
    logic                  w_fault;
    logic                  w_unused_addr;

    // Byte offset bits carry no information for word-aligned requests.
    assign w_unused_addr = ^ram_addr[1:0];

    // Any address bit above the word index marks the request out of range.
    assign w_oor = (ram_addr >> (ADDR_WIDTH + 2)) != 32'd0;

    assign ram_read_data = r_read_data;

    // Next-state, handshake outputs and the commit strobe. In IDLE the live
    // request fields are selected so a zero-wait access can commit on the
    // same edge that captures it.
    always_comb begin
        w_next     = r_state;
        w_commit   = 1'b0;
        ram_stall  = 1'b0;
        ram_ready  = 1'b0;
        addr_fault = 1'b0;
        w_index    = r_index;
        w_we       = r_we;
        w_wdata    = r_wdata;
        w_fault    = r_fault;
        case (r_state)
            S_IDLE: begin
                w_index = ram_addr[ADDR_WIDTH+1:2];
                w_we    = ram_write_en;
                w_wdata = ram_write_data;
                w_fault = w_oor;
                if (ram_en) begin
                    ram_stall = 1'b1;
                    if (LP_WAIT == 4'd0) begin
                        w_next   = S_RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                ram_stall = 1'b1;
                if (r_count == 4'd1) begin
                    w_next   = S_RESP;
                    w_commit = 1'b1;
                end
            end
            S_RESP: begin
                ram_ready  = 1'b1;
                addr_fault = r_fault;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the request in IDLE and count wait states down in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'd0;
            r_index <= '0;
            r_we    <= 4'd0;
            r_wdata <= 32'd0;
            r_fault <= 1'b0;
        end else if (r_state == S_IDLE && ram_en) begin
            r_count <= LP_WAIT;
            r_index <= ram_addr[ADDR_WIDTH+1:2];
            r_we    <= ram_write_en;
            r_wdata <= ram_write_data;
            r_fault <= w_oor;
        end else if (r_state == S_WAIT) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Response data: the stored word for in-range reads, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= 32'd0;
        end else if (w_commit) begin
            if (w_we != 4'd0 || w_fault) begin
                r_read_data <= 32'd0;
            end else begin
                r_read_data <= r_mem[w_index];
            end
        end
    end

    // Storage array: only enabled lanes of in-range writes are updated, and
    // never while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_we[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
